// File: rtl/jellyvl_etherneco_synctimer_slave_ctl.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_synctimer_slave_ctl
//
// Sync-timer slave controller for a ring network node.
//  * Parses the command frame: byte 0 = command, bytes 1..TIME_BYTES = master
//    time (little-endian), then one OFFSET_BYTES slot per node starting at
//    SLOT_BASE. At frame end, publishes correct_time = time + own offset.
//  * Measures the turnaround between the command-frame start and the
//    response-frame start, and writes it into this node's response slot.
//
// Ports
//  clk, rst                        clock, asynchronous active-high reset
//  free_run_time                   local free-running timer
//  cmd_rx_start/end/error          command frame events
//  cmd_rx_node                     this node's 1-based index (0 = no slot)
//  s_cmd_first/pos/data/valid      command byte stream
//  res_rx_start/error              response frame events
//  s_res_pos/valid                 response byte stream
//  m_res_data/valid                replacement byte for the response stream
//  correct_time/renew/valid        corrected time output
//  elapsed_time                    last measured turnaround
//  status_frame_error              one-cycle pulse for a rejected frame
// ---------------------------------------------------------------------------
module jellyvl_etherneco_synctimer_slave_ctl #(
    parameter int TIMER_WIDTH   = 64,
    parameter int TIME_BYTES    = 8,
    parameter int OFFSET_BYTES  = 4,
    parameter int ELAPSED_BYTES = 4,
    parameter int SLOT_BASE     = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIMER_WIDTH-1:0]     free_run_time,
    input  logic                       cmd_rx_start,
    input  logic                       cmd_rx_end,
    input  logic                       cmd_rx_error,
    input  logic [7:0]                 cmd_rx_node,
    input  logic                       s_cmd_first,
    input  logic [15:0]                s_cmd_pos,
    input  logic [7:0]                 s_cmd_data,
    input  logic                       s_cmd_valid,
    input  logic                       res_rx_start,
    input  logic                       res_rx_error,
    input  logic [15:0]                s_res_pos,
    input  logic                       s_res_valid,
    output logic [7:0]                 m_res_data,
    output logic                       m_res_valid,
    output logic [TIMER_WIDTH-1:0]     correct_time,
    output logic                       correct_renew,
    output logic                       correct_valid,
    output logic [8*ELAPSED_BYTES-1:0] elapsed_time,
    output logic                       status_frame_error
);

    localparam int TW = 8 * TIME_BYTES;
    localparam int OW = 8 * OFFSET_BYTES;
    localparam int EW = 8 * ELAPSED_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TIME     = 3'd1,
        ST_SEEK     = 3'd2,
        ST_OFFSET   = 3'd3,
        ST_WAIT_END = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cmd_q, cmd_d;          // only valid/renew bits are used
    logic [TW-1:0]          time_q, time_d;
    logic [OW-1:0]          offset_q, offset_d;
    logic [TIMER_WIDTH-1:0] correct_time_q, correct_time_d;
    logic                   correct_valid_q, correct_valid_d;
    logic                   correct_renew_q, correct_renew_d;
    logic                   frame_error_q, frame_error_d;
    logic [EW-1:0]          start_time_q, start_time_d;
    logic                   start_seen_q, start_seen_d;
    logic [EW-1:0]          elapsed_q, elapsed_d;
    logic                   m_res_valid_q, m_res_valid_d;
    logic [7:0]             m_res_data_q, m_res_data_d;

    // Slot arithmetic is deliberately 16-bit so overflow wraps naturally.
    logic [15:0] node16_s;
    logic [15:0] cmd_slot_s;
    logic [15:0] res_slot_s;
    logic [15:0] time_k_s;
    logic [15:0] offset_k_s;
    logic [15:0] res_k_s;
    logic [EW-1:0] frt_low_s;

    assign node16_s   = {8'd0, cmd_rx_node};
    assign cmd_slot_s = 16'(SLOT_BASE) + 16'(OFFSET_BYTES) * (node16_s - 16'd1);
    assign res_slot_s = 16'(SLOT_BASE) + 16'(ELAPSED_BYTES) * (node16_s - 16'd1);
    assign time_k_s   = s_cmd_pos - 16'd1;
    assign offset_k_s = s_cmd_pos - cmd_slot_s;
    assign res_k_s    = s_res_pos - res_slot_s;
    assign frt_low_s  = EW'(free_run_time);

    // Next-state logic: command parser, turnaround measurement, response slot.
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        time_d          = time_q;
        offset_d        = offset_q;
        correct_time_d  = correct_time_q;
        correct_valid_d = 1'b0;
        correct_renew_d = 1'b0;
        frame_error_d   = 1'b0;
        start_time_d    = start_time_q;
        start_seen_d    = start_seen_q;
        elapsed_d       = elapsed_q;
        m_res_valid_d   = 1'b0;
        m_res_data_d    = 8'd0;

        // Command side: error beats start, start beats end, end beats data.
        if (cmd_rx_error) begin
            state_d = ST_IDLE;
        end else if (cmd_rx_start) begin
            start_time_d = frt_low_s;
            start_seen_d = 1'b1;
            state_d      = ST_IDLE;
        end else if (cmd_rx_end) begin
            state_d = ST_IDLE;
            case (state_q)
                ST_WAIT_END: begin
                    correct_time_d  = TIMER_WIDTH'(time_q) + TIMER_WIDTH'(offset_q);
                    correct_valid_d = cmd_q[0];
                    correct_renew_d = cmd_q[0] & cmd_q[1];
                end
                ST_IDLE: begin
                    frame_error_d = 1'b0;
                end
                default: begin
                    frame_error_d = 1'b1;
                end
            endcase
        end else if (s_cmd_valid) begin
            if (s_cmd_first) begin
                cmd_d    = s_cmd_data[1:0];
                time_d   = '0;
                offset_d = '0;
                state_d  = ST_TIME;
            end else begin
                case (state_q)
                    ST_TIME: begin
                        for (int i = 0; i < TIME_BYTES; i++) begin
                            if (time_k_s == 16'(i)) begin
                                time_d[8*i +: 8] = s_cmd_data;
                            end
                        end
                        if (time_k_s == 16'(TIME_BYTES - 1)) begin
                            state_d = ST_SEEK;
                        end else begin
                            state_d = ST_TIME;
                        end
                    end
                    ST_SEEK: begin
                        if ((cmd_rx_node != 8'd0) && (s_cmd_pos == cmd_slot_s)) begin
                            offset_d[7:0] = s_cmd_data;
                            state_d = (OFFSET_BYTES == 1) ? ST_WAIT_END : ST_OFFSET;
                        end else begin
                            state_d = ST_SEEK;
                        end
                    end
                    ST_OFFSET: begin
                        for (int i = 1; i < OFFSET_BYTES; i++) begin
                            if (offset_k_s == 16'(i)) begin
                                offset_d[8*i +: 8] = s_cmd_data;
                            end
                        end
                        if (offset_k_s == 16'(OFFSET_BYTES - 1)) begin
                            state_d = ST_WAIT_END;
                        end else begin
                            state_d = ST_OFFSET;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end

        // Turnaround: without a preceding command start the value is unknown.
        if (res_rx_start && !res_rx_error) begin
            if (start_seen_q) begin
                elapsed_d = frt_low_s - start_time_q;
            end else begin
                elapsed_d = '1;
            end
        end else begin
            elapsed_d = elapsed_q;
        end

        // Response slot replacement; a response error suppresses the byte.
        if (s_res_valid && !res_rx_error && (cmd_rx_node != 8'd0)
                && (res_k_s < 16'(ELAPSED_BYTES))) begin
            m_res_valid_d = 1'b1;
            for (int i = 0; i < ELAPSED_BYTES; i++) begin
                if (res_k_s == 16'(i)) begin
                    m_res_data_d = elapsed_q[8*i +: 8];
                end
            end
        end else begin
            m_res_valid_d = 1'b0;
            m_res_data_d  = 8'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cmd_q           <= 2'd0;
            time_q          <= '0;
            offset_q        <= '0;
            correct_time_q  <= '0;
            correct_valid_q <= 1'b0;
            correct_renew_q <= 1'b0;
            frame_error_q   <= 1'b0;
            start_time_q    <= '0;
            start_seen_q    <= 1'b0;
            elapsed_q       <= '0;
            m_res_valid_q   <= 1'b0;
            m_res_data_q    <= 8'd0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            time_q          <= time_d;
            offset_q        <= offset_d;
            correct_time_q  <= correct_time_d;
            correct_valid_q <= correct_valid_d;
            correct_renew_q <= correct_renew_d;
            frame_error_q   <= frame_error_d;
            start_time_q    <= start_time_d;
            start_seen_q    <= start_seen_d;
            elapsed_q       <= elapsed_d;
            m_res_valid_q   <= m_res_valid_d;
            m_res_data_q    <= m_res_data_d;
        end
    end

    assign correct_time       = correct_time_q;
    assign correct_valid      = correct_valid_q;
    assign correct_renew      = correct_renew_q;
    assign status_frame_error = frame_error_q;
    assign elapsed_time       = elapsed_q;
    assign m_res_valid        = m_res_valid_q;
    assign m_res_data         = m_res_data_q;

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for jellyvl_etherneco_synctimer_slave_ctl (default parameters).
// Expected correction and response-byte results are queued when stimulus is
// driven and popped when the registered outputs are due.
// ---------------------------------------------------------------------------
module tb_jellyvl_etherneco_synctimer_slave_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] free_run_time = 64'd0;
    logic        cmd_rx_start = 1'b0, cmd_rx_end = 1'b0, cmd_rx_error = 1'b0;
    logic [7:0]  cmd_rx_node = 8'd0;
    logic        s_cmd_first = 1'b0;
    logic [15:0] s_cmd_pos = 16'd0;
    logic [7:0]  s_cmd_data = 8'd0;
    logic        s_cmd_valid = 1'b0;
    logic        res_rx_start = 1'b0, res_rx_error = 1'b0;
    logic [15:0] s_res_pos = 16'd0;
    logic        s_res_valid = 1'b0;
    logic [7:0]  m_res_data;
    logic        m_res_valid;
    logic [63:0] correct_time;
    logic        correct_renew, correct_valid;
    logic [31:0] elapsed_time;
    logic        status_frame_error;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        valid;
        logic        renew;
        logic        err;
        logic [63:0] t;
    } corr_exp_t;

    typedef struct {
        logic       valid;
        logic [7:0] data;
    } res_exp_t;

    corr_exp_t corr_q[$];
    res_exp_t  res_q[$];

    jellyvl_etherneco_synctimer_slave_ctl dut (
        .clk                (clk),
        .rst                (rst),
        .free_run_time      (free_run_time),
        .cmd_rx_start       (cmd_rx_start),
        .cmd_rx_end         (cmd_rx_end),
        .cmd_rx_error       (cmd_rx_error),
        .cmd_rx_node        (cmd_rx_node),
        .s_cmd_first        (s_cmd_first),
        .s_cmd_pos          (s_cmd_pos),
        .s_cmd_data         (s_cmd_data),
        .s_cmd_valid        (s_cmd_valid),
        .res_rx_start       (res_rx_start),
        .res_rx_error       (res_rx_error),
        .s_res_pos          (s_res_pos),
        .s_res_valid        (s_res_valid),
        .m_res_data         (m_res_data),
        .m_res_valid        (m_res_valid),
        .correct_time       (correct_time),
        .correct_renew      (correct_renew),
        .correct_valid      (correct_valid),
        .elapsed_time       (elapsed_time),
        .status_frame_error (status_frame_error)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Stream command bytes 0..last_pos for the given node layout.
    task automatic send_bytes(input logic [7:0] cmd, input logic [63:0] t,
                              input logic [7:0] node, input logic [31:0] off,
                              input int last_pos);
        int slot;
        slot = 9 + 4 * (int'(node) - 1);
        cmd_rx_node = node;
        for (int p = 0; p <= last_pos; p++) begin
            s_cmd_valid = 1'b1;
            s_cmd_first = (p == 0);
            s_cmd_pos   = 16'(p);
            if (p == 0)
                s_cmd_data = cmd;
            else if (p <= 8)
                s_cmd_data = t[8*(p-1) +: 8];
            else if (node != 8'd0 && p >= slot && p < slot + 4)
                s_cmd_data = off[8*(p-slot) +: 8];
            else
                s_cmd_data = 8'h55;
            cycle();
        end
        s_cmd_valid = 1'b0;
        s_cmd_first = 1'b0;
    endtask

    // Drive cmd_rx_end (optionally with error) and check the queued result.
    task automatic end_frame(input string name, input logic with_err,
                             input logic ev, input logic er, input logic ee,
                             input logic [63:0] et);
        corr_exp_t e;
        corr_q.push_back('{ev, er, ee, et});
        cmd_rx_end   = 1'b1;
        cmd_rx_error = with_err;
        cycle();
        cmd_rx_end   = 1'b0;
        cmd_rx_error = 1'b0;
        e = corr_q.pop_front();
        n_cmp++;
        if (correct_valid !== e.valid || correct_renew !== e.renew ||
            status_frame_error !== e.err) begin
            n_bad++;
            $display("FAIL %s flags: got valid=%b renew=%b err=%b, want valid=%b renew=%b err=%b",
                     name, correct_valid, correct_renew, status_frame_error,
                     e.valid, e.renew, e.err);
        end
        if (e.valid) begin
            n_cmp++;
            if (correct_time !== e.t) begin
                n_bad++;
                $display("FAIL %s time: got %h want %h", name, correct_time, e.t);
            end
        end
    endtask

    // Stream response positions and compare each replacement one cycle later.
    task automatic run_response(input string name, input int p0, input int p1,
                                input logic [31:0] el, input logic err);
        res_exp_t e;
        for (int p = p0; p <= p1; p++) begin
            s_res_valid  = 1'b1;
            s_res_pos    = 16'(p);
            res_rx_error = err;
            if (!err && p >= 9 && p < 13)
                res_q.push_back('{1'b1, el[8*(p-9) +: 8]});
            else
                res_q.push_back('{1'b0, 8'd0});
            cycle();
            e = res_q.pop_front();
            n_cmp++;
            if (m_res_valid !== e.valid || m_res_data !== e.data) begin
                n_bad++;
                $display("FAIL %s pos %0d: got valid=%b data=%h want valid=%b data=%h",
                         name, p, m_res_valid, m_res_data, e.valid, e.data);
            end
        end
        s_res_valid  = 1'b0;
        res_rx_error = 1'b0;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (correct_valid !== 1'b0 || correct_renew !== 1'b0 || correct_time !== 64'd0 ||
            status_frame_error !== 1'b0 || m_res_valid !== 1'b0 || m_res_data !== 8'd0 ||
            elapsed_time !== 32'd0) begin
            n_bad++;
            $display("FAIL %s: got cv=%b cr=%b ct=%h fe=%b mv=%b md=%h el=%h, want all zero",
                     name, correct_valid, correct_renew, correct_time, status_frame_error,
                     m_res_valid, m_res_data, elapsed_time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        check_zero("reset");
        rst = 1'b0;
        cycle();
        check_zero("after_reset");
    endtask

    task automatic test_elapsed_no_start();
        free_run_time = 64'd500;
        res_rx_start  = 1'b1;
        cycle();
        res_rx_start  = 1'b0;
        n_cmp++;
        if (elapsed_time !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL elapsed_no_start: got %h want ffffffff", elapsed_time);
        end
        cmd_rx_node = 8'd1;
        run_response("resp_no_start", 9, 10, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_correct();
        send_bytes(8'h03, 64'h0000_0000_0000_1000, 8'd2, 32'h0000_0020, 24);
        end_frame("correct", 1'b0, 1'b1, 1'b1, 1'b0, 64'h1020);
    endtask

    task automatic test_wrap();
        send_bytes(8'h01, 64'hFFFF_FFFF_FFFF_FFF0, 8'd2, 32'h0000_0020, 16);
        end_frame("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 64'h10);
    endtask

    task automatic test_incomplete();
        send_bytes(8'h03, 64'h1234, 8'd2, 32'h0000_0020, 14);
        end_frame("incomplete", 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
        n_cmp++;
        cycle();
        if (status_frame_error !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_error_pulse: got %b want 0", status_frame_error);
        end
    endtask

    task automatic test_error_end();
        send_bytes(8'h03, 64'h5000, 8'd2, 32'h0000_0007, 20);
        end_frame("error_with_end", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic test_node_zero();
        send_bytes(8'h03, 64'h5000, 8'd0, 32'h0000_0007, 20);
        end_frame("node_zero", 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    endtask

    task automatic test_elapsed();
        free_run_time = 64'd100;
        cmd_rx_start  = 1'b1;
        cycle();
        cmd_rx_start  = 1'b0;
        free_run_time = 64'd350;
        res_rx_start  = 1'b1;
        cycle();
        res_rx_start  = 1'b0;
        n_cmp++;
        if (elapsed_time !== 32'd250) begin
            n_bad++;
            $display("FAIL elapsed: got %0d want 250", elapsed_time);
        end
        cmd_rx_node = 8'd1;
        run_response("resp_elapsed", 7, 14, 32'h0000_00FA, 1'b0);
        run_response("resp_error", 9, 10, 32'h0000_00FA, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_bytes(8'h03, 64'h0000_0000_0000_2000, 8'd2, 32'h0000_0040, 14);
        rst = 1'b1;
        #2;
        check_zero("reset_async");
        cycle();
        check_zero("reset_mid");
        rst = 1'b0;
        cycle();
        end_frame("end_without_first", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        send_bytes(8'h03, 64'h0000_0000_0000_2000, 8'd2, 32'h0000_0040, 16);
        end_frame("after_reset_frame", 1'b0, 1'b1, 1'b1, 1'b0, 64'h2040);
    endtask

    initial begin
        test_reset();
        test_elapsed_no_start();
        test_correct();
        test_wrap();
        test_incomplete();
        test_error_end();
        test_node_zero();
        test_elapsed();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jellyvl_etherneco_synctimer_slave_ctl.md
JELLYVL_ETHERNECO_SYNCTIMER_SLAVE_CTL -- requirements
Module: jellyvl_etherneco_synctimer_slave_ctl

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64: width of free-run and corrected time.
REQ-002 SHALL have parameter TIME_BYTES, default 8: length of the command time field, 1..8.
REQ-003 SHALL have parameter OFFSET_BYTES, default 4: length of each per-node offset slot, 1..8.
REQ-004 SHALL have parameter ELAPSED_BYTES, default 4: length of each per-node response slot, 1..8.
REQ-005 SHALL have parameter SLOT_BASE, default 9: byte position of node 1's slot in both command and response frames.
REQ-006 SHALL have one clock and one reset: clk input 1 is the clock; rst input 1 is the reset, asynchronous and active-high.
REQ-007 SHALL have these ports (name, direction, width, meaning):
- free_run_time in TIMER_WIDTH: local free-run timer.
- cmd_rx_start, cmd_rx_end, cmd_rx_error in 1 each: command frame events.
- cmd_rx_node in 8: this node's index, 1-based.
- s_cmd_first in 1, s_cmd_pos in 16, s_cmd_data in 8, s_cmd_valid in 1: command byte stream.
- res_rx_start, res_rx_error in 1 each: response frame events.
- s_res_pos in 16, s_res_valid in 1: response byte stream.
- m_res_data out 8, m_res_valid out 1: response byte replacement.
- correct_time out TIMER_WIDTH, correct_renew out 1, correct_valid out 1: correction output.
- elapsed_time out 8*ELAPSED_BYTES: last measured turnaround.
- status_frame_error out 1: one-cycle pulse for a rejected command frame.

Function
REQ-008 SHALL implement a parser FSM with states IDLE, TIME, SEEK, OFFSET, WAIT_END.
REQ-009 SHALL treat an accepted byte as s_cmd_valid=1.
- s_cmd_first=1 in any state: capture cmd_reg <= s_cmd_data, clear time and offset registers, go to TIME.
REQ-010 SHALL, in TIME, store byte k (k = s_cmd_pos-1, 0..TIME_BYTES-1) into time byte k, little-endian.
- After byte TIME_BYTES-1 the FSM goes to SEEK.
REQ-011 SHALL define slot = SLOT_BASE + OFFSET_BYTES*(cmd_rx_node-1), computed in 16 bits.
- In SEEK, a byte at s_cmd_pos==slot is stored as offset byte 0 and the FSM goes to OFFSET.
- OFFSET stores the following bytes up to byte OFFSET_BYTES-1, then goes to WAIT_END.
REQ-012 SHALL treat cmd_rx_node==0 as "no slot": SEEK never matches.
REQ-013 SHALL act on cmd_rx_end as follows:
- In WAIT_END, the next cycle drives correct_valid=cmd_reg[0] and correct_renew=cmd_reg[1], then the FSM returns to IDLE.
- In any other non-IDLE state, the next cycle pulses status_frame_error, keeps correct_valid=0, and the FSM returns to IDLE.
REQ-014 SHALL compute correct_time = time + zero-extended offset, modulo 2^TIMER_WIDTH.
- correct_time is registered and stable while correct_valid=1.
- correct_renew=0 whenever correct_valid=0.
REQ-015 SHALL give cmd_rx_error priority over all other same-cycle events: FSM to IDLE, no correct_valid, no status_frame_error.
REQ-016 SHALL handle cmd_rx_start as follows:
- Capture start_time <= low 8*ELAPSED_BYTES bits of free_run_time.
- Set start_seen=1.
- The FSM goes to IDLE.
REQ-017 SHALL update elapsed_time on res_rx_start with no res_rx_error in the same cycle:
- If start_seen=1: elapsed_time <= (free_run_time low bits - start_time) mod 2^(8*ELAPSED_BYTES).
- If start_seen=0: elapsed_time <= all ones.
REQ-018 SHALL replace response bytes with a registered one-cycle latency:
- When s_res_valid=1 and s_res_pos==slot_r+i (0<=i<ELAPSED_BYTES, node!=0), drive m_res_data=elapsed_time byte i and m_res_valid=1 the next cycle.
- slot_r = SLOT_BASE + ELAPSED_BYTES*(node-1).
- Otherwise m_res_valid=0 and m_res_data=0.
REQ-019 SHALL clear m_res_valid on the cycle after res_rx_error.
REQ-020 SHALL handle position wrap-around without special casing: a slot computation that overflows 16 bits wraps modulo 2^16.

Reset
REQ-021 SHALL, while rst=1, hold these values: FSM=IDLE; correct_valid=0, correct_renew=0, correct_time=0; status_frame_error=0; m_res_valid=0, m_res_data=0; elapsed_time=0, start_time=0, start_seen=0.
REQ-022 SHALL, on a reset asserted mid-frame, discard the partial frame; the first valid output afterwards requires a new s_cmd_first.

Verification
REQ-023 SHALL pass these directed scenarios (default parameters):
- Node 2 (slot 13). Cmd 0x03, time 0x0000_0000_0000_1000, offset 0x0000_0020 at pos 13..16, then cmd_rx_end -> one cycle later: correct_valid=1, correct_renew=1, correct_time=0x1020.
- Time 0xFFFF_FFFF_FFFF_FFF0, offset 0x20 -> correct_time=0x10 (wrap).
- Frame ending at pos 14 (offset incomplete) -> status_frame_error pulse, correct_valid=0.
- cmd_rx_error at the same cycle as cmd_rx_end -> no outputs.
- cmd_rx_start at free_run 100, res_rx_start at 350, node 1 -> response pos 9..12 return 0xFA,0x00,0x00,0x00 with m_res_valid one cycle after each byte.
- res_rx_start with no prior cmd_rx_start -> elapsed_time=0xFFFF_FFFF.
- Reset asserted during OFFSET -> all outputs zero; the next complete frame is processed normally.
